// File: rtl/uart_pkg.sv
// Shared encodings and the LFSR step function for the UART test-pattern path.
package uart_pkg;

    typedef enum logic [1:0] {
        MODE_CNT   = 2'd0,
        MODE_LFSR  = 2'd1,
        MODE_CONST = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SEND
    } state_t;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Fibonacci x^8+x^6+x^5+x^4+1: shift left, feedback = xor of taps 7,5,4,3.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/uart_lfsr8.sv
// 8-bit pattern LFSR; kept standalone so the RX checker can track the same sequence.
module uart_lfsr8
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seed,
    input  logic       step,
    output logic [7:0] state
);

    logic [7:0] seed_eff;

    // An all-zero seed would lock the register, so it is replaced by 8'h01.
    assign seed_eff = (seed == '0) ? 8'h01 : seed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= seed_eff;
        end else if (step) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/uart_tx_pattern_gen.sv
// Periodic burst source of counter / LFSR / constant bytes for the UART TX byte port.
module uart_tx_pattern_gen
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CNT_W     = 26,
    parameter int unsigned PERIOD    = 10000000,
    parameter int unsigned BURST_LEN = 16,
    parameter logic [7:0]  BASE_CHAR = 8'h30,
    parameter int unsigned CHAR_SPAN = 16,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] const_data,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    output logic              burst_done,
    output logic              busy,
    output logic [15:0]       tx_count
);

    localparam int unsigned     BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD - 1);
    localparam logic [7:0]        SEQ_LAST  = 8'(CHAR_SPAN - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [7:0]          seq_q, seq_d;
    mode_t               burst_mode_q, burst_mode_d;
    logic [DATA_W-1:0]   burst_const_q, burst_const_d;
    logic                tx_valid_d, burst_done_d, busy_d;
    logic [DATA_W-1:0]   tx_data_d;
    logic [15:0]         tx_count_d;
    logic [7:0]          lfsr_q, lfsr_after;
    logic                lfsr_step, handshake;

    function automatic logic [DATA_W-1:0] pattern(input mode_t m, input logic [DATA_W-1:0] c,
                                                  input logic [7:0] s, input logic [7:0] l);
        logic [7:0] ch;
        ch = BASE_CHAR + s;
        case (m)
            MODE_LFSR:  return DATA_W'(l);
            MODE_CONST: return c;
            default:    return DATA_W'(ch);
        endcase
    endfunction

    uart_lfsr8 u_lfsr (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .seed  (LFSR_SEED),
        .step  (lfsr_step),
        .state (lfsr_q)
    );

    assign handshake = tx_valid & tx_ready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        beat_d        = beat_q;
        seq_d         = seq_q;
        burst_mode_d  = burst_mode_q;
        burst_const_d = burst_const_q;
        tx_valid_d    = tx_valid;
        tx_data_d     = tx_data;
        burst_done_d  = 1'b0;
        tx_count_d    = tx_count;
        lfsr_step     = 1'b0;
        lfsr_after    = lfsr_q;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    burst_mode_d  = mode_t'(mode);
                    burst_const_d = const_data;
                    state_d       = ST_SEND;
                    tx_valid_d    = 1'b1;
                    tx_data_d     = pattern(mode_t'(mode), const_data, seq_q, lfsr_q);
                    cnt_d         = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SEND: begin
                if (handshake) begin
                    tx_count_d = tx_count + 16'd1;
                    // Only the pattern source in use for this burst advances.
                    case (burst_mode_q)
                        MODE_LFSR: begin
                            lfsr_step  = 1'b1;
                            lfsr_after = lfsr_next(lfsr_q);
                        end
                        MODE_CONST: ;
                        default:   seq_d = (seq_q == SEQ_LAST) ? '0 : seq_q + 8'd1;
                    endcase
                    if (beat_q == LAST_BEAT) begin
                        tx_valid_d   = 1'b0;
                        burst_done_d = 1'b1;
                        beat_d       = '0;
                        cnt_d        = '0;
                        state_d      = enable ? ST_WAIT : ST_IDLE;
                    end else if (!enable) begin
                        tx_valid_d = 1'b0;
                        beat_d     = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        beat_d    = beat_q + BEAT_W'(1);
                        tx_data_d = pattern(burst_mode_q, burst_const_q, seq_d, lfsr_after);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            beat_q        <= '0;
            seq_q         <= '0;
            burst_mode_q  <= MODE_CNT;
            burst_const_q <= '0;
            tx_valid      <= 1'b0;
            tx_data       <= '0;
            burst_done    <= 1'b0;
            busy          <= 1'b0;
            tx_count      <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            beat_q        <= beat_d;
            seq_q         <= seq_d;
            burst_mode_q  <= burst_mode_d;
            burst_const_q <= burst_const_d;
            tx_valid      <= tx_valid_d;
            tx_data       <= tx_data_d;
            burst_done    <= burst_done_d;
            busy          <= busy_d;
            tx_count      <= tx_count_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_pattern_gen.sv
// Directed bench for uart_tx_pattern_gen with a small pattern/count model.
module tb_uart_tx_pattern_gen;

    localparam int unsigned PERIOD    = 8;
    localparam int unsigned BURST_LEN = 4;
    localparam int unsigned CHAR_SPAN = 16;
    localparam logic [7:0]  BASE_CHAR = 8'h30;
    localparam logic [7:0]  SEED      = 8'hA5;

    logic        sys_clk = 1'b0;
    logic        sys_rst, enable, tx_ready;
    logic [1:0]  mode;
    logic [7:0]  const_data;
    logic        tx_valid, burst_done, busy;
    logic [7:0]  tx_data;
    logic [15:0] tx_count;

    int vec_count = 0;
    int err_count = 0;

    int         m_seq;
    logic [7:0] m_lfsr;
    int         m_count;

    uart_tx_pattern_gen #(
        .DATA_W    (8),
        .CNT_W     (26),
        .PERIOD    (PERIOD),
        .BURST_LEN (BURST_LEN),
        .BASE_CHAR (BASE_CHAR),
        .CHAR_SPAN (CHAR_SPAN),
        .LFSR_SEED (SEED)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .enable     (enable),
        .mode       (mode),
        .const_data (const_data),
        .tx_ready   (tx_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .burst_done (burst_done),
        .busy       (busy),
        .tx_count   (tx_count)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic model_reset;
        m_seq   = 0;
        m_lfsr  = SEED;
        m_count = 0;
    endtask

    function automatic logic [7:0] model_byte(input logic [1:0] m);
        case (m)
            2'd1:    return m_lfsr;
            2'd2:    return const_data;
            default: return 8'(BASE_CHAR + 8'(m_seq));
        endcase
    endfunction

    task automatic model_advance(input logic [1:0] m);
        m_count++;
        case (m)
            2'd1:    m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
            2'd2:    ;
            default: m_seq = (m_seq + 1) % CHAR_SPAN;
        endcase
    endtask

    // Edges until tx_valid rises, bounded.
    task automatic wait_valid(input int exp_lat);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!tx_valid && n < 40);
        check("latency", n, exp_lat);
    endtask

    task automatic run_burst(input logic [1:0] bmode, input logic [1:0] mid_mode, input int exp_lat,
                             input int stall_beat, input int stall_len);
        logic [7:0] e;
        mode = bmode;
        wait_valid(exp_lat);
        for (int b = 0; b < BURST_LEN; b++) begin
            e = model_byte(bmode);
            if (b == 1) mode = mid_mode;
            if (b == stall_beat) begin
                tx_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    check("stall_valid", tx_valid, 1);
                    check("stall_data", tx_data, e);
                    check("stall_count", tx_count, m_count);
                end
                tx_ready = 1'b1;
            end
            check("valid", tx_valid, 1);
            check("data", tx_data, e);
            check("busy", busy, 1);
            check("done_low", burst_done, 0);
            tick();
            model_advance(bmode);
        end
        check("done_pulse", burst_done, 1);
        check("valid_off", tx_valid, 0);
        check("count", tx_count, m_count);
        tick();
        check("done_once", burst_done, 0);
    endtask

    initial begin
        logic [7:0] e;
        sys_rst    = 1'b1;
        enable     = 1'b0;
        mode       = 2'd0;
        const_data = 8'h5A;
        tx_ready   = 1'b1;
        model_reset();
        tick();
        tick();
        check("rst_valid", tx_valid, 0);
        check("rst_data", tx_data, 0);
        check("rst_done", burst_done, 0);
        check("rst_busy", busy, 0);
        check("rst_count", tx_count, 0);

        // Counter bursts: 30..33, 34..37, then wrap through 3C..3F back to 30.
        sys_rst = 1'b0;
        enable  = 1'b1;
        run_burst(2'd0, 2'd0, 9, -1, 0);
        run_burst(2'd0, 2'd0, 7, -1, 0);
        check("count_two_bursts", tx_count, 8);
        run_burst(2'd0, 2'd0, 7, -1, 0);
        run_burst(2'd0, 2'd0, 7, -1, 0);
        run_burst(2'd0, 2'd0, 7, -1, 0);
        check("count_five_bursts", tx_count, 20);

        // Asynchronous reset while a byte is offered.
        mode = 2'd0;
        wait_valid(7);
        check("pre_rst_valid", tx_valid, 1);
        tx_ready = 1'b0;
        #2 sys_rst = 1'b1;
        #1;
        check("mid_rst_valid", tx_valid, 0);
        check("mid_rst_count", tx_count, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", tx_data, 0);
        tick();
        sys_rst  = 1'b0;
        tx_ready = 1'b1;
        model_reset();

        // Restart at 30, with 5-cycle backpressure on 31.
        run_burst(2'd0, 2'd0, 9, 1, 5);

        // Enable dropped while the third byte is stalled.
        mode = 2'd0;
        wait_valid(7);
        for (int b = 0; b < 2; b++) begin
            check("drop_data", tx_data, model_byte(2'd0));
            tick();
            model_advance(2'd0);
        end
        e        = model_byte(2'd0);
        tx_ready = 1'b0;
        enable   = 1'b0;
        check("drop_offer", tx_data, e);
        for (int s = 0; s < 2; s++) begin
            tick();
            check("drop_hold_valid", tx_valid, 1);
            check("drop_hold_data", tx_data, e);
            check("drop_hold_busy", busy, 1);
        end
        tx_ready = 1'b1;
        tick();
        model_advance(2'd0);
        check("drop_valid_off", tx_valid, 0);
        check("drop_no_done", burst_done, 0);
        check("drop_busy", busy, 0);
        check("drop_count", tx_count, m_count);
        tick();
        check("idle_no_done", burst_done, 0);
        check("idle_busy", busy, 0);
        check("idle_valid", tx_valid, 0);
        enable = 1'b1;
        run_burst(2'd0, 2'd0, 9, -1, 0);

        // LFSR burst from the seed; a mid-burst switch back to counter must be ignored.
        run_burst(2'd1, 2'd0, 7, -1, 0);
        run_burst(2'd0, 2'd0, 7, -1, 0);
        // Constant, then reserved mode behaving as counter.
        run_burst(2'd2, 2'd2, 7, -1, 0);
        run_burst(2'd3, 2'd3, 7, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
